// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the shared total-length helper.
package vga_timing_pkg;

   localparam int unsigned vga_h_active = 640;
   localparam int unsigned vga_h_front  = 16;
   localparam int unsigned vga_h_sync   = 96;
   localparam int unsigned vga_h_back   = 48;
   localparam int unsigned vga_v_active = 480;
   localparam int unsigned vga_v_front  = 10;
   localparam int unsigned vga_v_sync   = 2;
   localparam int unsigned vga_v_back   = 33;

   // Full period of one axis from its four region lengths.
   function automatic int unsigned total_len(input int unsigned active,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
      return active + front + sync + back;
   endfunction

endpackage

// File: rtl/pixel_strobe_gen.sv
// Divides the system clock by R into a one-clk pixel strobe.
module pixel_strobe_gen #(
   parameter int unsigned R = 2
) (
   input  logic clk,
   input  logic rst,
   output logic pixel_en
);

   localparam int unsigned w_c  = (R > 1) ? $clog2(R) : 1;
   localparam logic [w_c-1:0] last = w_c'(R - 1);

   logic [w_c-1:0] div;

   // Strobe is registered from the terminal count, so the first one lands R clks after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         div      <= '0;
         pixel_en <= 1'b0;
      end else begin
         div      <= (div == last) ? '0 : div + w_c'(1);
         pixel_en <= (div == last);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: sync, blanking, position and a lookahead fetch position, all registered.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned clk_mhz   = 50,
   parameter int unsigned pixel_mhz = 25,
   parameter int unsigned h_active  = vga_h_active,
   parameter int unsigned h_front   = vga_h_front,
   parameter int unsigned h_sync    = vga_h_sync,
   parameter int unsigned h_back    = vga_h_back,
   parameter int unsigned v_active  = vga_v_active,
   parameter int unsigned v_front   = vga_v_front,
   parameter int unsigned v_sync    = vga_v_sync,
   parameter int unsigned v_back    = vga_v_back,
   parameter logic        hsync_pol = 1'b0,
   parameter logic        vsync_pol = 1'b0,
   parameter int unsigned lookahead = 2,
   localparam int unsigned h_total  = total_len(h_active, h_front, h_sync, h_back),
   localparam int unsigned v_total  = total_len(v_active, v_front, v_sync, v_back),
   localparam int unsigned w_x      = $clog2(h_total),
   localparam int unsigned w_y      = $clog2(v_total)
) (
   input  logic           clk,
   input  logic           rst,
   output logic           pixel_en,
   output logic           hsync,
   output logic           vsync,
   output logic           display_on,
   output logic [w_x-1:0] x,
   output logic [w_y-1:0] y,
   output logic           line_start,
   output logic           frame_start,
   output logic [w_x-1:0] fetch_x,
   output logic [w_y-1:0] fetch_y,
   output logic           fetch_valid
);

   localparam int unsigned ratio    = clk_mhz / pixel_mhz;
   localparam int unsigned hs_start = h_active + h_front;
   localparam int unsigned hs_end   = hs_start + h_sync;
   localparam int unsigned vs_start = v_active + v_front;
   localparam int unsigned vs_end   = vs_start + v_sync;
   localparam logic [w_x-1:0] h_last  = w_x'(h_total - 1);
   localparam logic [w_y-1:0] v_last  = w_y'(v_total - 1);
   localparam logic [w_x-1:0] hf_init = w_x'(lookahead % h_total);

   logic [w_x-1:0] h, hf;
   logic [w_y-1:0] v, vf;
   logic           in_hsync, in_vsync, in_display, in_fetch;

   pixel_strobe_gen #(.R(ratio)) u_strobe (
      .clk      (clk),
      .rst      (rst),
      .pixel_en (pixel_en)
   );

   // Region decode of the current raster and fetch positions.
   always_comb begin
      in_hsync   = (32'(h) >= hs_start) && (32'(h) < hs_end);
      in_vsync   = (32'(v) >= vs_start) && (32'(v) < vs_end);
      in_display = (32'(h) < h_active) && (32'(v) < v_active);
      in_fetch   = (32'(hf) < h_active) && (32'(vf) < v_active);
   end

   // Outputs capture the decode of (h,v) on each strobe while the counters step forward.
   always_ff @(posedge clk) begin
      if (rst) begin
         h           <= '0;
         v           <= '0;
         hf          <= hf_init;
         vf          <= '0;
         hsync       <= ~hsync_pol;
         vsync       <= ~vsync_pol;
         display_on  <= 1'b0;
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         fetch_x     <= '0;
         fetch_y     <= '0;
         fetch_valid <= 1'b0;
      end else if (pixel_en) begin
         x           <= h;
         y           <= v;
         display_on  <= in_display;
         hsync       <= in_hsync ? hsync_pol : ~hsync_pol;
         vsync       <= in_vsync ? vsync_pol : ~vsync_pol;
         line_start  <= (h == '0);
         frame_start <= (h == '0) && (v == '0);
         fetch_x     <= hf;
         fetch_y     <= vf;
         fetch_valid <= in_fetch;

         if (h == h_last) begin
            h <= '0;
            v <= (v == v_last) ? '0 : v + w_y'(1);
         end else begin
            h <= h + w_x'(1);
         end

         if (hf == h_last) begin
            hf <= '0;
            vf <= (vf == v_last) ? '0 : vf + w_y'(1);
         end else begin
            hf <= hf + w_x'(1);
         end
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing (both polarities), a tiny raster with lookahead 2 and with lookahead 0.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_d, rst_s;

   logic       d_pe, d_hs, d_vs, d_on, d_ls, d_fs, d_fv;
   logic [9:0] d_x, d_y, d_fx, d_fy;
   logic       p_pe, p_hs, p_vs, p_on, p_ls, p_fs, p_fv;
   logic [9:0] p_x, p_y, p_fx, p_fy;
   logic       s_pe, s_hs, s_vs, s_on, s_ls, s_fs, s_fv;
   logic [3:0] s_x, s_fx;
   logic [2:0] s_y, s_fy;
   logic       z_pe, z_hs, z_vs, z_on, z_ls, z_fs, z_fv;
   logic [3:0] z_x, z_fx;
   logic [2:0] z_y, z_fy;

   vga_timing_gen u_def (
      .clk(clk), .rst(rst_d), .pixel_en(d_pe), .hsync(d_hs), .vsync(d_vs), .display_on(d_on),
      .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs),
      .fetch_x(d_fx), .fetch_y(d_fy), .fetch_valid(d_fv));

   vga_timing_gen #(.hsync_pol(1'b1), .vsync_pol(1'b1)) u_pol (
      .clk(clk), .rst(rst_d), .pixel_en(p_pe), .hsync(p_hs), .vsync(p_vs), .display_on(p_on),
      .x(p_x), .y(p_y), .line_start(p_ls), .frame_start(p_fs),
      .fetch_x(p_fx), .fetch_y(p_fy), .fetch_valid(p_fv));

   vga_timing_gen #(.clk_mhz(25), .pixel_mhz(25), .h_active(8), .h_front(1), .h_sync(2), .h_back(1),
                    .v_active(4), .v_front(1), .v_sync(1), .v_back(1), .lookahead(2)) u_sml (
      .clk(clk), .rst(rst_s), .pixel_en(s_pe), .hsync(s_hs), .vsync(s_vs), .display_on(s_on),
      .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs),
      .fetch_x(s_fx), .fetch_y(s_fy), .fetch_valid(s_fv));

   vga_timing_gen #(.clk_mhz(25), .pixel_mhz(25), .h_active(8), .h_front(1), .h_sync(2), .h_back(1),
                    .v_active(4), .v_front(1), .v_sync(1), .v_back(1), .lookahead(0)) u_z (
      .clk(clk), .rst(rst_s), .pixel_en(z_pe), .hsync(z_hs), .vsync(z_vs), .display_on(z_on),
      .x(z_x), .y(z_y), .line_start(z_ls), .frame_start(z_fs),
      .fetch_x(z_fx), .fetch_y(z_fy), .fetch_valid(z_fv));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Default 800x525 raster at R=2, lookahead 2; n = clk edges since reset released (0 = in reset).
   function automatic logic [63:0] def_model(input int n, input logic pol);
      int   p, px, py, q, qx, qy;
      logic pe, hs, vs, on, ls, fs, fv, ld;
      pe = (n > 0) && (n % 2 == 0);
      px = 0; py = 0; qx = 0; qy = 0;
      hs = ~pol; vs = ~pol; on = 1'b0; ls = 1'b0; fs = 1'b0; fv = 1'b0;
      if (n >= 3) begin
         p  = (n - 3) / 2;
         ld = (n % 2 == 1);
         px = p % 800;
         py = (p / 800) % 525;
         q  = p + 2;
         qx = q % 800;
         qy = (q / 800) % 525;
         on = (px < 640) && (py < 480);
         hs = ((px >= 656) && (px < 752)) ? pol : ~pol;
         vs = ((py >= 490) && (py < 492)) ? pol : ~pol;
         ls = ld && (px == 0);
         fs = ld && (px == 0) && (py == 0);
         fv = (qx < 640) && (qy < 480);
      end
      return {17'd0, pe, hs, vs, on, ls, fs, fv, 10'(px), 10'(py), 10'(qx), 10'(qy)};
   endfunction

   // Tiny 12x7 raster at R=1 with the given lookahead.
   function automatic logic [63:0] sml_model(input int n, input int la);
      int   p, px, py, q, qx, qy;
      logic pe, hs, vs, on, ls, fs, fv;
      pe = (n >= 1);
      px = 0; py = 0; qx = 0; qy = 0;
      hs = 1'b1; vs = 1'b1; on = 1'b0; ls = 1'b0; fs = 1'b0; fv = 1'b0;
      if (n >= 2) begin
         p  = n - 2;
         px = p % 12;
         py = (p / 12) % 7;
         q  = p + la;
         qx = q % 12;
         qy = (q / 12) % 7;
         on = (px < 8) && (py < 4);
         hs = !((px >= 9) && (px < 11));
         vs = (py != 5);
         ls = (px == 0);
         fs = (px == 0) && (py == 0);
         fv = (qx < 8) && (qy < 4);
      end
      return {43'd0, pe, hs, vs, on, ls, fs, fv, 4'(px), 3'(py), 4'(qx), 3'(qy)};
   endfunction

   typedef struct {
      int         p;
      logic [3:0] x;
      logic [2:0] y;
      logic       on, hs, vs, ls, fs;
      logic [3:0] fx;
      logic [2:0] fy;
      logic       fv;
   } vec_t;

   vec_t tbl [13];

   task automatic check_def(input int n);
      check($sformatf("def_n%0d", n),
            {17'd0, d_pe, d_hs, d_vs, d_on, d_ls, d_fs, d_fv, d_x, d_y, d_fx, d_fy}, def_model(n, 1'b0));
      check($sformatf("pol_n%0d", n),
            {17'd0, p_pe, p_hs, p_vs, p_on, p_ls, p_fs, p_fv, p_x, p_y, p_fx, p_fy}, def_model(n, 1'b1));
   endtask

   task automatic check_z(input int n);
      check($sformatf("la0_n%0d", n),
            {43'd0, z_pe, z_hs, z_vs, z_on, z_ls, z_fs, z_fv, z_x, z_y, z_fx, z_fy}, sml_model(n, 0));
   endtask

   initial begin
      int n;
      logic [63:0] exp_v;
      //          p   x     y     on    hs    vs    ls    fs    fx    fy    fv
      tbl[0]  = '{0,  4'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 3'd0, 1'b1};
      tbl[1]  = '{7,  4'd7, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 3'd0, 1'b0};
      tbl[2]  = '{9,  4'd9, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd11,3'd0, 1'b0};
      tbl[3]  = '{10, 4'd10,3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 3'd1, 1'b1};
      tbl[4]  = '{11, 4'd11,3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 3'd1, 1'b1};
      tbl[5]  = '{12, 4'd0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 3'd1, 1'b1};
      tbl[6]  = '{48, 4'd0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 3'd4, 1'b0};
      tbl[7]  = '{60, 4'd0, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 3'd5, 1'b0};
      tbl[8]  = '{70, 4'd10,3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd6, 1'b0};
      tbl[9]  = '{82, 4'd10,3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 1'b1};
      tbl[10] = '{83, 4'd11,3'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 3'd0, 1'b1};
      tbl[11] = '{84, 4'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 3'd0, 1'b1};
      tbl[12] = '{95, 4'd11,3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 3'd1, 1'b1};

      rst_d = 1'b1;
      rst_s = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_def(0);

      // Default raster: first strobe, frame_start, one full line plus wrap into line 1.
      @(negedge clk);
      rst_d = 1'b0;
      n = 0;
      while (n < 3803) begin
         @(posedge clk);
         n++;
         #1;
         check_def(n);
      end
      check("mid_pos", 64'({d_x, d_y}), 64'({10'd300, 10'd2}));

      // Mid-frame reset held 3 clks, then a clean restart.
      @(negedge clk);
      rst_d = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check_def(0);
      end
      @(negedge clk);
      rst_d = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         check_def(k);
      end

      // Tiny raster: table of hand-computed vectors, lookahead-0 instance checked every clk.
      check("sml_reset", 64'({s_pe, s_hs, s_vs, s_on, s_ls, s_fs, s_fv, s_x, s_y, s_fx, s_fy}),
            64'({7'b0110000, 14'd0}));
      check_z(0);
      @(negedge clk);
      rst_s = 1'b0;
      n = 0;
      @(posedge clk);
      n++;
      #1;
      check("sml_first_strobe", 64'({s_pe, s_fs, s_ls, s_x}), 64'({3'b100, 4'd0}));
      check_z(n);
      for (int i = 0; i < 13; i++) begin
         while (n < tbl[i].p + 2) begin
            @(posedge clk);
            n++;
            #1;
            check_z(n);
         end
         exp_v = 64'({1'b1, tbl[i].x, tbl[i].y, tbl[i].on, tbl[i].hs, tbl[i].vs, tbl[i].ls,
                      tbl[i].fs, tbl[i].fx, tbl[i].fy, tbl[i].fv});
         check($sformatf("sml_p%0d", tbl[i].p),
               64'({s_pe, s_x, s_y, s_on, s_hs, s_vs, s_ls, s_fs, s_fx, s_fy, s_fv}), exp_v);
      end
      while (n < 180) begin
         @(posedge clk);
         n++;
         #1;
         check_z(n);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
